// File: rtl/arb_pkg.sv
// Shared arbitration types and helpers: state encoding, sizes and the
// round-robin pick function reused by the 16-way arbiter and later variants.
package arb_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    GRANT = 2'd2
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Returns the first set request at or after ptr, wrapping modulo N_REQ.
  // Scanning from the farthest candidate back to ptr lets the nearest one win.
  function automatic rr_pick_t next_rr(input logic [N_REQ-1:0] req,
                                       input logic [IDX_W-1:0] ptr);
    rr_pick_t         pick;
    logic [IDX_W-1:0] cand;
    pick = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        pick.found = 1'b1;
        pick.idx   = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter_4x16_if.sv
// Request/grant bundle between requesting agents and the arbiter.
// Signal suffixes are from the arbiter's point of view.
interface rr_arbiter_4x16_if;

  logic                          en_i;
  logic [arb_pkg::N_REQ-1:0]     req_i;
  logic                          release_i;
  logic                          gnt_valid_o;
  logic [arb_pkg::IDX_W-1:0]     gnt_idx_o;
  logic [arb_pkg::N_REQ-1:0]     gnt_onehot_o;
  logic                          timeout_o;

  // Arbiter side.
  modport slave (
    input  en_i, req_i, release_i,
    output gnt_valid_o, gnt_idx_o, gnt_onehot_o, timeout_o
  );

  // Requester side.
  modport master (
    output en_i, req_i, release_i,
    input  gnt_valid_o, gnt_idx_o, gnt_onehot_o, timeout_o
  );

endinterface

// File: rtl/arb_dec_4x16.sv
// 4-to-16 one-hot decoder with an enable; all zeros when disabled.
module arb_dec_4x16
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] onehot_o
);

  // Decode the index into a single select line when enabled.
  always_comb begin
    // NOTE: assigning a default before any conditional write keeps this
    // purely combinational; a missed branch would otherwise infer a latch.
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter_4x16.sv
// 16-requester round-robin arbiter with hold/release handshake, a
// forced revoke after MAX_HOLD grant cycles and a one-cycle turnaround gap.
module rr_arbiter_4x16
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 15,  // 1..255
  parameter int CNT_W    = 8    // 2**CNT_W > MAX_HOLD
) (
  input  logic              clk,
  input  logic              rst,
  rr_arbiter_4x16_if.slave  bus
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  rr_pick_t         pick;

  // Register all arbiter state; reset is synchronous and beats every input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: select in IDLE, hold/end in GRANT, turnaround in GAP.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    pick      = next_rr(bus.req_i, ptr_q);

    unique case (state_q)
      IDLE: begin
        if (bus.en_i && pick.found) begin
          idx_d   = pick.idx;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end

      GRANT: begin
        // A release or a dropped request always wins over the hold limit,
        // so a coinciding timeout is treated as a normal end.
        if (bus.release_i || !bus.req_i[idx_q]) begin
          valid_d = 1'b0;
          idx_d   = '0;
          ptr_d   = idx_q + IDX_W'(1);
          state_d = GAP;
        end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          valid_d   = 1'b0;
          idx_d     = '0;
          ptr_d     = idx_q + IDX_W'(1);
          timeout_d = 1'b1;
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      GAP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        idx_d   = '0;
      end
    endcase
  end

  arb_dec_4x16 u_dec (
    .idx_i    (idx_q),
    .en_i     (valid_q),
    .onehot_o (bus.gnt_onehot_o)
  );

  assign bus.gnt_valid_o = valid_q;
  assign bus.gnt_idx_o   = idx_q;
  assign bus.timeout_o   = timeout_q;

endmodule
